mist_io_spi_master: RTL and testbench

- SPI master that plays the role of the ARM IO controller towards the core's user_io SPI slave (SPI_SCK / CONF_DATA0 / SPI_DI / SPI_DO).
- Used on boards without an ARM controller (e.g. the DECA HDMI build) and in simulation to drive OSD/status commands.
- Sends one frame per request: a command byte, then 0..15 payload bytes, MSB first, SPI mode 0. Every byte shifted in on MISO is returned to the requester.

---
 rtl/mist_io_spi_master.sv | 154 +++++++++++++++
 tb/tb_mist_io_spi_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mist_io_spi_master.sv
// SPI mode-0 master standing in for the ARM IO controller towards user_io:
// sends a command byte plus up to 15 payload bytes and returns every MISO byte.
module mist_io_spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [3:0] len,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_ss_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    generate
        if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : g_bad_div
            $error("mist_io_spi_master: CLK_DIV must be within 2..255");
        end
    endgenerate

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t     state, state_nx;
    logic [7:0] ph;
    logic [6:0] bit_cnt;
    logic [3:0] len_q;
    logic [7:0] tx_sh;
    logic [7:0] tx_buf;
    logic [7:0] rx_sh;
    logic       sck_q;
    logic       mosi_q;
    logic       phase_end;
    logic       last_bit;
    logic       byte_last_bit;

    assign phase_end     = (ph == PH_LAST);
    assign last_bit      = (bit_cnt == {len_q, 3'b111});
    assign byte_last_bit = (bit_cnt[2:0] == 3'b111);

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_ss_n = !((state == SHIFT) || (state == HOLD));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: if (phase_end && sck_q && last_bit) state_nx = HOLD;
            HOLD:  if (phase_end) state_nx = GAP;
            GAP:   if (phase_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            ph       <= '0;
            bit_cnt  <= '0;
            len_q    <= '0;
            tx_sh    <= '0;
            tx_buf   <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (tx_req) tx_buf <= tx_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        ph      <= '0;
                        bit_cnt <= '0;
                        sck_q   <= 1'b0;
                        mosi_q  <= cmd[7];
                        tx_sh   <= {cmd[6:0], 1'b0};
                    end
                end
                SHIFT: begin
                    if (!phase_end) begin
                        ph <= ph + 8'd1;
                    end else begin
                        ph <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            rx_sh <= {rx_sh[6:0], spi_miso};
                            if (byte_last_bit) begin
                                rx_data  <= {rx_sh[6:0], spi_miso};
                                rx_valid <= 1'b1;
                                // Request the next payload byte early enough that it
                                // is in tx_buf before this bit's falling edge.
                                if (bit_cnt[6:3] < len_q) tx_req <= 1'b1;
                            end
                        end else begin
                            sck_q   <= 1'b0;
                            bit_cnt <= bit_cnt + 7'd1;
                            if (!last_bit) begin
                                if (byte_last_bit) begin
                                    mosi_q <= tx_buf[7];
                                    tx_sh  <= {tx_buf[6:0], 1'b0};
                                end else begin
                                    mosi_q <= tx_sh[7];
                                    tx_sh  <= {tx_sh[6:0], 1'b0};
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!phase_end) begin
                        ph <= ph + 8'd1;
                    end else begin
                        ph     <= '0;
                        done   <= 1'b1;
                        mosi_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (!phase_end) ph <= ph + 8'd1;
                    else            ph <= '0;
                end
                default: ph <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mist_io_spi_master.sv
// Directed bench for mist_io_spi_master: one instance at CLK_DIV=2 and one at
// CLK_DIV=3, with a cycle-level SPI slave model driven from the test sequence.
module tb_mist_io_spi_master;

    logic       clk;
    logic       reset_in;
    logic       start2, start3;
    logic [7:0] cmd;
    logic [3:0] len;
    logic [7:0] tx_data;
    logic       miso;

    logic       tx_req2, rx_valid2, busy2, done2, sck2, ss_n2, mosi2;
    logic [7:0] rx_data2;
    logic       tx_req3, rx_valid3, busy3, done3, sck3, ss_n3, mosi3;
    logic [7:0] rx_data3;

    int errors = 0;
    int checks = 0;

    logic [7:0] pay[16];
    logic [7:0] mb[16];

    mist_io_spi_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset_in(reset_in), .start(start2), .cmd(cmd), .len(len),
        .tx_req(tx_req2), .tx_data(tx_data), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .busy(busy2), .done(done2), .spi_sck(sck2), .spi_ss_n(ss_n2),
        .spi_mosi(mosi2), .spi_miso(miso)
    );

    mist_io_spi_master #(.CLK_DIV(3)) dut3 (
        .clk(clk), .reset_in(reset_in), .start(start3), .cmd(cmd), .len(len),
        .tx_req(tx_req3), .tx_data(tx_data), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .busy(busy3), .done(done3), .spi_sck(sck3), .spi_ss_n(ss_n3),
        .spi_mosi(mosi3), .spi_miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the selected instance and checks it against the
    // protocol timing; exp_done is the hand-computed frame-end cycle.
    task automatic run_frame(input int d, input logic [7:0] c, input logic [3:0] l,
                             input int exp_done, input bit ign, input string tag);
        int n, rises, txr, rxv, ndone, done_cyc, busy0, first_txr;
        int tim_err, mosi_err, hold_err, ssfall, ssrise, pidx;
        logic [7:0] srx[16];
        logic [7:0] rvals[16];
        logic psck, pmosi;
        logic [7:0] prxd;
        logic o_sck, o_mosi, o_ssn, o_txr, o_rxv, o_done, o_busy;
        logic [7:0] o_rxd;
        rises = 0; txr = 0; rxv = 0; ndone = 0; done_cyc = -1; busy0 = -1;
        first_txr = -1; tim_err = 0; mosi_err = 0; hold_err = 0;
        ssfall = -1; ssrise = -1; pidx = 0;
        for (int i = 0; i < 16; i++) begin srx[i] = '0; rvals[i] = '0; end

        @(negedge clk);
        cmd = c; len = l; miso = mb[0][7];
        if (d == 2) start2 = 1'b1; else start3 = 1'b1;
        psck = 1'b0; pmosi = 1'b0;
        prxd = (d == 2) ? rx_data2 : rx_data3;

        for (n = 1; n < 3000; n++) begin
            @(negedge clk);
            start2 = 1'b0; start3 = 1'b0;
            if (n == 1) cmd = 8'hFF;
            if (d == 2) begin
                o_sck = sck2; o_mosi = mosi2; o_ssn = ss_n2; o_txr = tx_req2;
                o_rxv = rx_valid2; o_done = done2; o_busy = busy2; o_rxd = rx_data2;
            end else begin
                o_sck = sck3; o_mosi = mosi3; o_ssn = ss_n3; o_txr = tx_req3;
                o_rxv = rx_valid3; o_done = done3; o_busy = busy3; o_rxd = rx_data3;
            end
            if (o_sck && !psck) begin
                if (n != 1 + 2 * rises * d + d) tim_err++;
                if (rises < 128) srx[rises / 8] = {srx[rises / 8][6:0], o_mosi};
                rises++;
            end
            if (rises < 128) miso = mb[rises / 8][7 - (rises % 8)];
            if ((o_mosi !== pmosi) && (n != 1) && !(psck && !o_sck) && !o_done) mosi_err++;
            if (o_txr) begin
                if (txr == 0) first_txr = n;
                txr++;
                tx_data = pay[pidx % 16];
                pidx++;
            end
            if (o_rxv) begin
                if (rxv < 16) rvals[rxv] = o_rxd;
                rxv++;
            end else if (o_rxd !== prxd) begin
                hold_err++;
            end
            if (!o_ssn && ssfall < 0) ssfall = n;
            if (o_ssn && ssfall >= 0 && ssrise < 0) ssrise = n;
            if (o_done) begin
                ndone++;
                done_cyc = n;
                if (ign) begin
                    if (d == 2) start2 = 1'b1; else start3 = 1'b1;
                end
            end
            if (ign && n == 40) begin
                if (d == 2) start2 = 1'b1; else start3 = 1'b1;
            end
            if (!o_busy) begin
                busy0 = n;
                break;
            end
            psck = o_sck; pmosi = o_mosi; prxd = o_rxd;
        end
        start2 = 1'b0; start3 = 1'b0;

        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " busy_low_cycle"}, busy0, exp_done + d);
        chk({tag, " ss_fall_cycle"}, ssfall, 1);
        chk({tag, " ss_rise_cycle"}, ssrise, exp_done);
        chk({tag, " sck_pulses"}, rises, 8 * (l + 1));
        chk({tag, " sck_timing_errs"}, tim_err, 0);
        chk({tag, " mosi_edge_errs"}, mosi_err, 0);
        chk({tag, " rx_hold_errs"}, hold_err, 0);
        chk({tag, " tx_req_count"}, txr, l);
        if (l != 0) chk({tag, " first_tx_req_cycle"}, first_txr, 1 + 15 * d);
        chk({tag, " rx_valid_count"}, rxv, l + 1);
        for (int i = 0; i <= l; i++) begin
            chk($sformatf("%s slave_byte%0d", tag, i), srx[i], (i == 0) ? c : pay[i - 1]);
            chk($sformatf("%s rx_byte%0d", tag, i), rvals[i], mb[i]);
        end
        if (ign) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk({tag, " no_queued_start"}, {(d == 2) ? busy2 : busy3, (d == 2) ? ss_n2 : ss_n3}, 2'b01);
            end
        end
    endtask

    initial begin
        reset_in = 1'b0; start2 = 1'b0; start3 = 1'b0;
        cmd = '0; len = '0; tx_data = '0; miso = 1'b0;
        for (int i = 0; i < 16; i++) begin pay[i] = '0; mb[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst ss_n", ss_n2, 1'b1);
        chk("rst sck", sck2, 1'b0);
        chk("rst mosi/busy/done", {mosi2, busy2, done2, tx_req2, rx_valid2}, 5'b0);
        chk("rst rx_data", rx_data2, 8'h00);
        reset_in = 1'b1;
        repeat (2) @(negedge clk);

        // D=2, cmd 0x15 + one payload byte; slave returns 0xA5, 0x3C
        pay[0] = 8'h01; mb[0] = 8'hA5; mb[1] = 8'h3C;
        run_frame(2, 8'h15, 4'd1, 67, 1'b0, "d2_len1");

        // D=2, command only
        mb[0] = 8'h96;
        run_frame(2, 8'h14, 4'd0, 35, 1'b0, "d2_len0");

        // D=3, maximum payload length
        for (int i = 0; i < 15; i++) pay[i] = 8'(i);
        for (int i = 0; i < 16; i++) mb[i] = 8'(8'hC0 + i * 3);
        run_frame(3, 8'hC3, 4'd15, 772, 1'b0, "d3_len15");

        // D=3, starts during SHIFT and in the done cycle must be dropped
        pay[0] = 8'h7E; pay[1] = 8'hC4; mb[0] = 8'h5F; mb[1] = 8'h01; mb[2] = 8'hE8;
        run_frame(3, 8'h81, 4'd2, 148, 1'b1, "d3_ignore");

        // asynchronous reset in the high phase of bit 3
        @(negedge clk);
        cmd = 8'h33; len = 4'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (22) @(negedge clk);
        chk("mid pre-reset sck", {sck3, ss_n3, busy3}, 3'b101);
        #1 reset_in = 1'b0;
        #1;
        chk("mid rst ss_n", ss_n3, 1'b1);
        chk("mid rst sck", sck3, 1'b0);
        chk("mid rst busy/done/mosi", {busy3, done3, mosi3, tx_req3, rx_valid3}, 5'b0);
        chk("mid rst rx_data", rx_data3, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("mid rst no_done", {done3, busy3}, 2'b00);
        end
        reset_in = 1'b1;
        @(negedge clk);
        chk("post rst idle", {done3, busy3, ss_n3}, 3'b001);

        pay[0] = 8'h24; mb[0] = 8'h81; mb[1] = 8'h7A;
        run_frame(3, 8'h5A, 4'd1, 100, 1'b0, "d3_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
